// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder: decoded record in, 32-bit instruction word out.
// Two-stage elastic pipeline (S1 raw record, S2 encoded word + error flag).
module rv32_instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_err
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } rec_t;

  logic        s1_valid;
  rec_t        s1_rec;
  logic        s2_valid;
  logic [31:0] s2_word;
  logic        s2_err;

  logic        s2_adv;
  logic        in_fire;
  logic [31:0] enc_word;
  logic        enc_err;

  assign s2_adv   = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;

  assign out_valid = s2_valid;
  assign out_word  = s2_word;
  assign out_err   = s2_err;

  // NOTE: only the valid bits need reset; the payload is qualified by them,
  // so the S1 record register is left without reset and loads on accept only.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_rec <= '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
                  rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 word/err are reset too so out_word reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_word  <= 32'h0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      s2_word  <= enc_err ? 32'h0 : enc_word;
      s2_err   <= enc_err;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Immediate range checks: upper bits must be a pure sign extension.
  logic [31:0] imm;
  logic        imm_is_ok;
  logic        imm_b_ok;
  logic        imm_j_ok;
  logic        imm_u_ok;

  assign imm       = s1_rec.imm;
  assign imm_is_ok = (&imm[31:11]) || !(|imm[31:11]);
  assign imm_b_ok  = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
  assign imm_j_ok  = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
  assign imm_u_ok  = !(|imm[11:0]);

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    enc_word = 32'h0;
    enc_err  = 1'b0;
    case (s1_rec.fmt)
      FMT_R: enc_word = {s1_rec.funct7, s1_rec.rs2, s1_rec.rs1, s1_rec.funct3,
                         s1_rec.rd, s1_rec.opcode};
      FMT_I: begin
        enc_word = {imm[11:0], s1_rec.rs1, s1_rec.funct3, s1_rec.rd, s1_rec.opcode};
        enc_err  = !imm_is_ok;
      end
      FMT_S: begin
        enc_word = {imm[11:5], s1_rec.rs2, s1_rec.rs1, s1_rec.funct3, imm[4:0],
                    s1_rec.opcode};
        enc_err  = !imm_is_ok;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], s1_rec.rs2, s1_rec.rs1, s1_rec.funct3,
                    imm[4:1], imm[11], s1_rec.opcode};
        enc_err  = !imm_b_ok;
      end
      FMT_U: begin
        enc_word = {imm[31:12], s1_rec.rd, s1_rec.opcode};
        enc_err  = !imm_u_ok;
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], s1_rec.rd, s1_rec.opcode};
        enc_err  = !imm_j_ok;
      end
      default: enc_err = 1'b1;
    endcase
    if (s1_rec.opcode[1:0] != 2'b11) enc_err = 1'b1;
  end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Self-checking bench for rv32_instr_encoder: directed vector table, backpressure
// and reset sequences, then randomized traffic against an arithmetic reference model.
module tb_rv32_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_err;

  always #5 clk = ~clk;

  rv32_instr_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_err(out_err)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } rec_t;

  typedef struct {
    string       name;
    rec_t        r;
    logic [31:0] word;
    logic        err;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];
  vec_t        vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input int fmt, input int op, input int f3, input int f7,
                              input int rd, input int rs1, input int rs2, input int imm);
    rec_t r;
    r.fmt = 3'(fmt); r.op = 7'(op); r.f3 = 3'(f3); r.f7 = 7'(f7);
    r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = 32'(imm);
    return r;
  endfunction

  // Field of an unsigned value by arithmetic: (v / 2^lo) mod 2^(hi-lo+1).
  function automatic longint fld(input longint v, input int hi, input int lo);
    return (v / (64'd1 << lo)) % (64'd1 << (hi - lo + 1));
  endfunction

  // Reference model: builds the word as a weighted sum of field values and
  // judges encodability by signed numeric range and alignment.
  function automatic logic [32:0] model(input rec_t r);
    longint u, s, w;
    bit bad;
    u = longint'(r.imm);
    s = longint'($signed(r.imm));
    bad = (r.fmt > 5) || (r.op % 4 != 3);
    w = r.op;
    case (r.fmt)
      0: w += r.rd * 128 + r.f3 * 4096 + r.rs1 * 32768 + r.rs2 * (64'd1 << 20)
              + r.f7 * (64'd1 << 25);
      1: begin
        bad |= (s < -2048) || (s > 2047);
        w += r.rd * 128 + r.f3 * 4096 + r.rs1 * 32768 + fld(u, 11, 0) * (64'd1 << 20);
      end
      2: begin
        bad |= (s < -2048) || (s > 2047);
        w += fld(u, 4, 0) * 128 + r.f3 * 4096 + r.rs1 * 32768 + r.rs2 * (64'd1 << 20)
             + fld(u, 11, 5) * (64'd1 << 25);
      end
      3: begin
        bad |= (s < -4096) || (s > 4095) || (u % 2 != 0);
        w += fld(u, 11, 11) * 128 + fld(u, 4, 1) * 256 + r.f3 * 4096 + r.rs1 * 32768
             + r.rs2 * (64'd1 << 20) + fld(u, 10, 5) * (64'd1 << 25)
             + fld(u, 12, 12) * (64'd1 << 31);
      end
      4: begin
        bad |= (u % 4096 != 0);
        w += r.rd * 128 + (u / 4096) * 4096;
      end
      5: begin
        bad |= (s < -1048576) || (s > 1048575) || (u % 2 != 0);
        w += r.rd * 128 + fld(u, 19, 12) * 4096 + fld(u, 11, 11) * (64'd1 << 20)
             + fld(u, 10, 1) * (64'd1 << 21) + fld(u, 20, 20) * (64'd1 << 31);
      end
      default: ;
    endcase
    if (bad) return {1'b1, 32'h0};
    return {1'b0, 32'(w)};
  endfunction

  // One clock cycle: present inputs, score any output transfer, queue any accepted record.
  task automatic cycle(input logic v, input rec_t r, input logic ordy, input logic [32:0] exp,
                       output logic in_f, output logic out_f);
    in_valid = v;
    in_fmt = r.fmt; in_opcode = r.op; in_funct3 = r.f3; in_funct7 = r.f7;
    in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2; in_imm = r.imm;
    out_ready = ordy;
    #1;
    in_f  = in_valid && in_ready;
    out_f = out_valid && out_ready;
    if (out_f) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got err=%b word=%h expected no output",
                 out_err, out_word);
      end else begin
        check("out_word", 64'({out_err, out_word}), 64'(exp_q.pop_front()));
      end
    end
    if (in_f) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int outs);
    logic inf, outf;
    rec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    outs = 0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      cycle(1'b0, z, 1'b1, 33'h0, inf, outf);
      if (outf) outs++;
    end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, z, 1'b1, 33'h0, inf, outf);
      if (outf) outs++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    int k;
    r.fmt = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    r.op  = {5'($urandom_range(0, 31)),
             ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 2)) : 2'b11};
    r.f3 = 3'($urandom); r.f7 = 7'($urandom);
    r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
    k = $urandom_range(0, 3);
    case (k)
      0: r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: r.imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      2: r.imm = 32'($urandom) & 32'hFFFF_F000;
      default: r.imm = 32'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    logic inf, outf;
    int lat, idx, cnt, outs;
    rec_t z, bp[8], r;
    logic [32:0] prev;
    bit have_prev;

    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = 0; in_opcode = 0; in_funct3 = 0; in_funct7 = 0;
    in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_word", 64'(out_word), 64'd0);
    check("reset_out_err", 64'(out_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors
    vecs.push_back('{"i_addi",   mk(1, 'h13, 0, 0, 1, 0, 0, 5),          32'h00500093, 1'b0});
    vecs.push_back('{"r_add",    mk(0, 'h33, 0, 0, 3, 1, 2, 0),          32'h002081B3, 1'b0});
    vecs.push_back('{"r_sub",    mk(0, 'h33, 0, 'h20, 3, 1, 2, 0),       32'h402081B3, 1'b0});
    vecs.push_back('{"u_lui",    mk(4, 'h37, 0, 0, 5, 0, 0, 'h12345000), 32'h123452B7, 1'b0});
    vecs.push_back('{"j_jal",    mk(5, 'h6F, 0, 0, 1, 0, 0, 8),          32'h008000EF, 1'b0});
    vecs.push_back('{"b_beq",    mk(3, 'h63, 0, 0, 0, 1, 2, 16),         32'h00208863, 1'b0});
    vecs.push_back('{"b_odd",    mk(3, 'h63, 0, 0, 0, 1, 2, 3),          32'h0, 1'b1});
    vecs.push_back('{"s_sw",     mk(2, 'h23, 2, 0, 0, 2, 1, -4),         32'hFE112E23, 1'b0});
    vecs.push_back('{"i_max",    mk(1, 'h13, 0, 0, 1, 0, 0, 2047),       32'h7FF00093, 1'b0});
    vecs.push_back('{"i_min",    mk(1, 'h13, 0, 0, 1, 0, 0, -2048),      32'h80000093, 1'b0});
    vecs.push_back('{"i_over",   mk(1, 'h13, 0, 0, 1, 0, 0, 2048),       32'h0, 1'b1});
    vecs.push_back('{"fmt7",     mk(7, 'h13, 0, 0, 1, 0, 0, 0),          32'h0, 1'b1});
    vecs.push_back('{"u_low",    mk(4, 'h37, 0, 0, 5, 0, 0, 1),          32'h0, 1'b1});
    vecs.push_back('{"b_max",    mk(3, 'h63, 0, 0, 0, 1, 2, 4094),       32'h7E208FE3, 1'b0});
    vecs.push_back('{"b_min",    mk(3, 'h63, 0, 0, 0, 1, 2, -4096),      32'h80208063, 1'b0});
    vecs.push_back('{"b_over",   mk(3, 'h63, 0, 0, 0, 1, 2, 4096),       32'h0, 1'b1});
    vecs.push_back('{"j_max",    mk(5, 'h6F, 0, 0, 1, 0, 0, 1048574),    32'h7FFFF0EF, 1'b0});
    vecs.push_back('{"j_min",    mk(5, 'h6F, 0, 0, 1, 0, 0, -1048576),   32'h800000EF, 1'b0});
    vecs.push_back('{"j_over",   mk(5, 'h6F, 0, 0, 1, 0, 0, 1048576),    32'h0, 1'b1});
    vecs.push_back('{"bad_op",   mk(1, 'h12, 0, 0, 1, 0, 0, 5),          32'h0, 1'b1});

    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].r, 1'b1, {vecs[i].err, vecs[i].word}, inf, outf);
      check({vecs[i].name, "_accept"}, 64'(inf), 64'd1);
      lat = 0;
      outf = 1'b0;
      while (!outf && lat < 10) begin
        cycle(1'b0, z, 1'b1, 33'h0, inf, outf);
        lat++;
      end
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd2);
    end
    check("table_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: 5 stalled cycles, then release
    for (int i = 0; i < 8; i++) bp[i] = mk(1, 'h13, 0, 0, i + 1, i, 0, i * 3);
    idx = 0;
    have_prev = 1'b0;
    for (int c = 0; c < 5; c++) begin
      r = (idx < 8) ? bp[idx] : z;
      cycle(idx < 8, r, 1'b0, model(r), inf, outf);
      if (inf) idx++;
      if (out_valid) begin
        if (have_prev) check("stall_stable", 64'({out_err, out_word}), 64'(prev));
        prev = {out_err, out_word};
        have_prev = 1'b1;
      end
    end
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      r = (idx < 8) ? bp[idx] : z;
      cycle(idx < 8, r, 1'b1, model(r), inf, outf);
      if (inf) idx++;
      if (outf) cnt++;
    end
    check("bp_throughput", 64'(cnt), 64'd8);
    check("bp_all_accepted", 64'(idx), 64'd8);
    drain(outs);

    // Reset with both stages full
    r = mk(1, 'h13, 0, 0, 9, 9, 0, 100);
    cycle(1'b1, r, 1'b0, model(r), inf, outf);
    cycle(1'b1, r, 1'b0, model(r), inf, outf);
    check("pre_rst_full", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_word", 64'(out_word), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    r = mk(0, 'h33, 0, 0, 7, 4, 5, 0);
    cycle(1'b1, r, 1'b1, model(r), inf, outf);
    drain(outs);
    check("post_rst_one_word", 64'(outs), 64'd1);

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      r = rand_rec();
      cycle($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0, model(r), inf, outf);
    end
    drain(outs);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
